// File: rtl/cu_pkg.sv
// Shared types and constants for the multicycle control-unit sequencer.
package cu_pkg;

  typedef enum logic [3:0] {
    FETCH        = 4'd0,
    DECODE       = 4'd1,
    MEMADR       = 4'd2,
    MEMREAD      = 4'd3,
    MEMWB        = 4'd4,
    MEMWRITE     = 4'd5,
    REXEC        = 4'd6,
    ALUWB        = 4'd7,
    BRANCH       = 4'd8,
    LINK         = 4'd9,
    JALPC        = 4'd10,
    AUIPC        = 4'd11,
    JALRPC       = 4'd12,
    IEXEC        = 4'd13,
    ILLEGAL      = 4'd14,
    STATE_UNUSED = 4'd15
  } stateT;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // States whose exit to FETCH marks the end of an instruction.
  function automatic logic isCompleting(input stateT s);
    case (s)
      MEMWB, MEMWRITE, ALUWB, BRANCH, JALPC, AUIPC, JALRPC: isCompleting = 1'b1;
      default:                                              isCompleting = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_next_state.sv
// Combinational next-state decoder for the control-unit sequencer.
module cu_next_state
  import cu_pkg::*;
(
  input  stateT      state,
  input  logic [6:0] Opcode,
  input  logic [6:0] OpReg,
  input  logic       MemReady,
  output stateT      nextState
);

  // Opcode is only looked at in DECODE; later decisions use the latched OpReg.
  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:    nextState = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: nextState = MEMADR;
          OP_RTYPE:          nextState = REXEC;
          OP_ITYPE:          nextState = IEXEC;
          OP_BRANCH:         nextState = BRANCH;
          OP_JAL, OP_JALR:   nextState = LINK;
          OP_AUIPC:          nextState = AUIPC;
          default:           nextState = ILLEGAL;
        endcase
      end
      MEMADR:   nextState = (OpReg == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  nextState = MemReady ? MEMWB : MEMREAD;
      MEMWRITE: nextState = MemReady ? FETCH : MEMWRITE;
      REXEC:    nextState = ALUWB;
      IEXEC:    nextState = ALUWB;
      LINK:     nextState = (OpReg == OP_JAL) ? JALPC : JALRPC;
      MEMWB, ALUWB, BRANCH, JALPC, AUIPC, JALRPC: nextState = FETCH;
      ILLEGAL:  nextState = ILLEGAL;
      default:  nextState = FETCH;
    endcase
  end

endmodule

// File: rtl/cu_sequencer.sv
// Multicycle control-unit sequencer: state, opcode latch and retire pulse.
// Optional performance counters are built when CU_PERF_CNT_EN is defined.
module cu_sequencer
  import cu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  Opcode,
  input  logic        MemReady,
  output logic [3:0]  StateRegister,
  output logic        Illegal,
  output logic        InstrRetired
`ifdef CU_PERF_CNT_EN
  ,
  output logic [31:0] CycleCount,
  output logic [31:0] InstRetCount
`endif
);

  stateT      state;
  stateT      nextState;
  logic [6:0] opReg;
  logic       retireNext;

  cu_next_state uNextState (
    .state     (state),
    .Opcode    (Opcode),
    .OpReg     (opReg),
    .MemReady  (MemReady),
    .nextState (nextState)
  );

  assign retireNext    = isCompleting(state) && (nextState == FETCH);
  assign StateRegister = state;
  assign Illegal       = (state == ILLEGAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      opReg        <= 7'd0;
      InstrRetired <= 1'b0;
    end else begin
      state        <= nextState;
      InstrRetired <= retireNext;
      if (state == DECODE) begin
        opReg <= Opcode;
      end
    end
  end

`ifdef CU_PERF_CNT_EN
  // Retire count advances on the same edge that raises InstrRetired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CycleCount   <= 32'd0;
      InstRetCount <= 32'd0;
    end else begin
      if (!(&CycleCount)) begin
        CycleCount <= CycleCount + 32'd1;
      end
      if (retireNext && !(&InstRetCount)) begin
        InstRetCount <= InstRetCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cu_sequencer.md
CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port list, clock and reset first (name, direction, width, meaning):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Opcode  input  7  instruction bits [6:0] from the instruction register.
- MemReady  input  1  memory has completed the current access.
- StateRegister  output  4  current state; feeds the control-output decoder.
- Illegal  output  1  high while in ILLEGAL.
- InstrRetired  output  1  one-cycle pulse when an instruction completes.

Function
REQ-003 State encodings SHALL be:
- 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE.
- 6 REXEC, 7 ALUWB, 8 BRANCH, 9 LINK, 10 JALPC, 11 AUIPC.
- 12 JALRPC, 13 IEXEC, 14 ILLEGAL; 15 is unused.
REQ-004 FETCH->DECODE SHALL occur only when MemReady=1; otherwise FETCH holds.
REQ-005 In DECODE the sequencer SHALL latch Opcode into OpReg.
REQ-006 DECODE next state SHALL be selected by Opcode:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> REXEC.
- 0010011 -> IEXEC.
- 1100011 -> BRANCH.
- 1101111 or 1100111 -> LINK.
- 0010111 -> AUIPC.
- any other value -> ILLEGAL (LUI included).
REQ-007 MEMADR SHALL go to MEMREAD if OpReg=0000011, else to MEMWRITE.
REQ-008 MEMREAD SHALL hold until MemReady=1, then go to MEMWB.
REQ-009 MEMWRITE SHALL hold until MemReady=1, then go to FETCH.
REQ-010 Fixed transitions:
- REXEC->ALUWB, IEXEC->ALUWB.
- MEMWB, ALUWB, BRANCH, JALPC, AUIPC, JALRPC -> FETCH.
REQ-011 LINK SHALL go to JALPC if OpReg=1101111, else to JALRPC.
REQ-012 ILLEGAL SHALL be absorbing until reset; Illegal=1 only in ILLEGAL.
REQ-013 State 15 SHALL go to FETCH on the next edge, with no InstrRetired pulse.
REQ-014 InstrRetired SHALL be registered and high for exactly the one cycle after a completing transition into FETCH. Completing transitions are from MEMWB, MEMWRITE, ALUWB, BRANCH, JALPC, AUIPC and JALRPC.
REQ-015 Opcode SHALL be sampled only in DECODE; Opcode changes in other states SHALL have no effect.
REQ-016 MemReady SHALL be ignored in every state except FETCH, MEMREAD and MEMWRITE.
REQ-017 Instruction latency in cycles, with MemReady=1 throughout:
- load 5, store 4, R/I-type 4, branch 3.
- JAL/JALR 4, AUIPC 3.

Reset
REQ-018 While rst_n=0 the outputs SHALL be: StateRegister=0 (FETCH), OpReg=0, Illegal=0, InstrRetired=0.
REQ-019 Reset asserted mid-instruction SHALL abort the instruction immediately, with no retire pulse.
REQ-020 The first state update after reset release SHALL occur on the first rising clk edge with rst_n=1.

Configuration
REQ-021 When macro CU_PERF_CNT_EN is defined, two output ports SHALL be added:
- CycleCount  output  32  increments every cycle out of reset, saturating at 0xFFFFFFFF.
- InstRetCount  output  32  increments on each InstrRetired pulse, also saturating.
REQ-022 Both counters SHALL reset to 0.
REQ-023 When CU_PERF_CNT_EN is undefined, those ports and their registers SHALL not exist.

Structure
REQ-024 Package cu_pkg SHALL hold the 4-bit state typedef, all state constants and the 7-bit opcode constants.
REQ-025 Next-state logic SHALL be a combinational sub-module cu_next_state (inputs: state, Opcode, OpReg, MemReady; output: next state).
REQ-026 The state, OpReg and retire-pulse registers SHALL live in cu_sequencer.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- R-type: Opcode=0110011, MemReady=1 -> states 0,1,6,7,0; InstrRetired=1 in the cycle after 7->0.
- Load with stall: Opcode=0000011, MemReady=0 for 3 cycles in MEMREAD -> state 3 held 4 cycles, then 4,0; latency 8.
- JALR: Opcode=1100111 -> states 0,1,9,12,0; changing Opcode to 1101111 during state 9 still goes to 12.
- Illegal: Opcode=0110111 -> 0,1,14; state 14 held ≥20 cycles, Illegal=1; rst_n pulse returns to 0.
- Reset mid-op: rst_n=0 asynchronously in state 3 -> StateRegister=0 immediately, InstrRetired=0.
- CU_PERF_CNT_EN: three back-to-back branches (Opcode=1100011) -> InstRetCount=3, CycleCount=9 after 9 cycles.
